// File: rtl/larpix_rx_pkg.sv
// -----------------------------------------------------------------------------
// larpix_rx_pkg
// Shared types and field positions for the LArPix receive packet router.
//   pkt_declare_t : 2-bit packet declaration in bits [1:0] of every packet.
//   *_LSB/*_MSB   : field positions inside a 63-bit LArPix packet.
//   rx_state_t    : states of the UART unload FSM.
// -----------------------------------------------------------------------------
package larpix_rx_pkg;

   typedef enum logic [1:0] {
      INVALID = 2'b00,
      DATA    = 2'b01,
      CFG_WR  = 2'b10,
      CFG_RD  = 2'b11
   } pkt_declare_t;

   localparam int DECLARE_LSB     = 0;
   localparam int DECLARE_MSB     = 1;
   localparam int CHIP_ID_LSB     = 2;
   localparam int CHIP_ID_MSB     = 9;
   localparam int CHANNEL_ID_LSB  = 10;
   localparam int CHANNEL_ID_MSB  = 15;
   localparam int REGMAP_ADDR_LSB = 10;
   localparam int REGMAP_ADDR_MSB = 17;
   localparam int REGMAP_DATA_LSB = 18;
   localparam int REGMAP_DATA_MSB = 25;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UNLOAD,
      ST_CAPTURE,
      ST_ROUTE,
      ST_WAIT_EMPTY
   } rx_state_t;

endpackage

// File: rtl/larpix_rx_packet_router_if.sv
// -----------------------------------------------------------------------------
// larpix_rx_packet_router_if
// Receive-UART link between uart_rx_fpga and the packet router.
//   rx_data      : received packet (WIDTH-1 bits)
//   rx_empty     : low while a packet waits in the UART
//   parity_error : parity flag accompanying rx_data
//   uld_rx_data  : unload strobe back to the UART
// Modports: master = UART side, slave = router side.
// -----------------------------------------------------------------------------
interface larpix_rx_packet_router_if #(
   parameter int WIDTH = 64
);
   logic [WIDTH-2:0] rx_data;
   logic             rx_empty;
   logic             parity_error;
   logic             uld_rx_data;

   modport master (
      output rx_data,
      output rx_empty,
      output parity_error,
      input  uld_rx_data
   );

   modport slave (
      input  rx_data,
      input  rx_empty,
      input  parity_error,
      output uld_rx_data
   );
endinterface

// File: rtl/larpix_rx_fifo.sv
// -----------------------------------------------------------------------------
// larpix_rx_fifo
// First-word-fall-through synchronous FIFO with occupancy count.
//   clk, reset : clock, asynchronous active-high reset
//   wr_en      : push request; accepted when not full or when popping too
//   wr_data    : push data
//   rd_en      : pop request; ignored while empty
//   rd_data    : head entry, valid while valid=1
//   valid      : FIFO not empty
//   full       : count == DEPTH
//   count      : occupancy, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module larpix_rx_fifo #(
   parameter int DATA_WIDTH = 63,
   parameter int DEPTH      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     rd_en,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  do_wr;
   logic                  do_rd;

   assign valid   = (count != '0);
   assign full    = (count == FULL_COUNT);
   assign do_rd   = rd_en & valid;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_wr   = wr_en & (~full | do_rd);
   assign rd_data = mem[rd_ptr];

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; entries are only visible after
   // being written, and leaving it unreset lets it map onto RAM.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/larpix_rx_packet_router.sv
// -----------------------------------------------------------------------------
// larpix_rx_packet_router
// Unloads LArPix packets from the receive UART, checks parity, decodes the
// packet declaration and routes: data packets to a FWFT FIFO, config-read
// replies to a response register, errors/drops to saturating counters.
//   clk, reset           : system clock, asynchronous active-high reset
//   uart (slave)         : rx_data / rx_empty / parity_error / uld_rx_data
//   data_pkt, data_valid : FIFO head and not-empty flag
//   data_ready           : consumer pop
//   fifo_count           : FIFO occupancy
//   cfg_rsp_*            : config-read reply (valid, chip id, addr, data)
//   cfg_rsp_ack          : clears cfg_rsp_valid
//   pkt_count, parity_err_count, bad_declare_count, drop_count : statistics
// Optional feature LARPIX_RX_CHIP_FILTER_EN adds filter_enable,
// filter_chip_id and filtered_count: data packets from other chips are
// discarded while filter_enable=1.
// -----------------------------------------------------------------------------
module larpix_rx_packet_router
   import larpix_rx_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   larpix_rx_packet_router_if.slave      uart,
   output logic [WIDTH-2:0]              data_pkt,
   output logic                          data_valid,
   input  logic                          data_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          cfg_rsp_valid,
   output logic [7:0]                    cfg_rsp_chip_id,
   output logic [7:0]                    cfg_rsp_addr,
   output logic [7:0]                    cfg_rsp_data,
   input  logic                          cfg_rsp_ack,
   output logic [CNT_WIDTH-1:0]          pkt_count,
   output logic [CNT_WIDTH-1:0]          parity_err_count,
   output logic [CNT_WIDTH-1:0]          bad_declare_count,
   output logic [CNT_WIDTH-1:0]          drop_count
`ifdef LARPIX_RX_CHIP_FILTER_EN
   ,
   input  logic                          filter_enable,
   input  logic [7:0]                    filter_chip_id,
   output logic [CNT_WIDTH-1:0]          filtered_count
`endif
);

   rx_state_t        state;
   logic             uld_q;
   logic             wait_cnt;
   logic [WIDTH-2:0] pkt_reg;
   logic             par_reg;

   pkt_declare_t     decl;
   logic             route;
   logic             push_req;
   logic             cfg_load;
   logic             bad_decl;
   logic             filt;
   logic             fifo_full;
   logic             fifo_drop;
   logic             cfg_drop;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign uart.uld_rx_data = uld_q;

   // Unload FSM. uld_q is set on the edges leaving UNLOAD and CAPTURE, so it
   // is high for exactly two cycles; the packet is latched on the second.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         uld_q    <= 1'b0;
         wait_cnt <= 1'b0;
         pkt_reg  <= '0;
         par_reg  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!uart.rx_empty) state <= ST_UNLOAD;
            end
            ST_UNLOAD: begin
               uld_q <= 1'b1;
               state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               uld_q   <= 1'b1;
               pkt_reg <= uart.rx_data;
               par_reg <= uart.parity_error;
               state   <= ST_ROUTE;
            end
            ST_ROUTE: begin
               uld_q    <= 1'b0;
               wait_cnt <= 1'b0;
               state    <= ST_WAIT_EMPTY;
            end
            ST_WAIT_EMPTY: begin
               // Give the UART two cycles to raise rx_empty; if it stays low
               // another packet is already waiting.
               if (uart.rx_empty)  state    <= ST_IDLE;
               else if (wait_cnt)  state    <= ST_UNLOAD;
               else                wait_cnt <= 1'b1;
            end
            default: begin
               uld_q <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Route decode of the latched packet, active only in ROUTE.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would infer a latch.
      route    = (state == ST_ROUTE);
      decl     = pkt_declare_t'(pkt_reg[DECLARE_MSB:DECLARE_LSB]);
      push_req = 1'b0;
      cfg_load = 1'b0;
      bad_decl = 1'b0;
      filt     = 1'b0;
      if (route && !par_reg) begin
         case (decl)
            INVALID: bad_decl = 1'b1;
            DATA: begin
`ifdef LARPIX_RX_CHIP_FILTER_EN
               if (filter_enable &&
                   (pkt_reg[CHIP_ID_MSB:CHIP_ID_LSB] != filter_chip_id))
                  filt = 1'b1;
               else
                  push_req = 1'b1;
`else
               push_req = 1'b1;
`endif
            end
            CFG_RD:  cfg_load = 1'b1;
            default: ;
         endcase
      end
   end

   // While full, data_valid is high, so data_ready alone means a pop.
   assign fifo_drop = push_req & fifo_full & ~data_ready;
   assign cfg_drop  = cfg_load & cfg_rsp_valid & ~cfg_rsp_ack;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pkt_count         <= '0;
         parity_err_count  <= '0;
         bad_declare_count <= '0;
         drop_count        <= '0;
         cfg_rsp_valid     <= 1'b0;
         cfg_rsp_chip_id   <= '0;
         cfg_rsp_addr      <= '0;
         cfg_rsp_data      <= '0;
      end else begin
         if (route)               pkt_count         <= sat_inc(pkt_count);
         if (route && par_reg)    parity_err_count  <= sat_inc(parity_err_count);
         if (bad_decl)            bad_declare_count <= sat_inc(bad_declare_count);
         if (fifo_drop || cfg_drop) drop_count      <= sat_inc(drop_count);
         // A new reply load takes priority over a coincident ack.
         if (cfg_load) begin
            cfg_rsp_valid   <= 1'b1;
            cfg_rsp_chip_id <= pkt_reg[CHIP_ID_MSB:CHIP_ID_LSB];
            cfg_rsp_addr    <= pkt_reg[REGMAP_ADDR_MSB:REGMAP_ADDR_LSB];
            cfg_rsp_data    <= pkt_reg[REGMAP_DATA_MSB:REGMAP_DATA_LSB];
         end else if (cfg_rsp_ack) begin
            cfg_rsp_valid   <= 1'b0;
         end
      end
   end

`ifdef LARPIX_RX_CHIP_FILTER_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     filtered_count <= '0;
      else if (filt) filtered_count <= sat_inc(filtered_count);
   end
`else
   logic unused_filt;
   assign unused_filt = filt;
`endif

   larpix_rx_fifo #(
      .DATA_WIDTH (WIDTH-1),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push_req),
      .wr_data (pkt_reg),
      .rd_en   (data_ready),
      .rd_data (data_pkt),
      .valid   (data_valid),
      .full    (fifo_full),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_larpix_rx_packet_router.sv
// -----------------------------------------------------------------------------
// tb_larpix_rx_packet_router
// Self-checking bench: a table of single-packet vectors (each after reset)
// plus hand-written sequences for latency, config replies, FIFO overflow and
// drain, reset mid-packet, and (with LARPIX_RX_CHIP_FILTER_EN) chip filtering.
// Counters are built 4 bits wide here so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_larpix_rx_packet_router;

   localparam int WIDTH      = 64;
   localparam int FIFO_DEPTH = 16;
   localparam int CNT_WIDTH  = 4;

   logic                       clk;
   logic                       reset;
   logic [WIDTH-2:0]           data_pkt;
   logic                       data_valid;
   logic                       data_ready;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                       cfg_rsp_valid;
   logic [7:0]                 cfg_rsp_chip_id;
   logic [7:0]                 cfg_rsp_addr;
   logic [7:0]                 cfg_rsp_data;
   logic                       cfg_rsp_ack;
   logic [CNT_WIDTH-1:0]       pkt_count;
   logic [CNT_WIDTH-1:0]       parity_err_count;
   logic [CNT_WIDTH-1:0]       bad_declare_count;
   logic [CNT_WIDTH-1:0]       drop_count;
`ifdef LARPIX_RX_CHIP_FILTER_EN
   logic                       filter_enable;
   logic [7:0]                 filter_chip_id;
   logic [CNT_WIDTH-1:0]       filtered_count;
`endif

   int total = 0;
   int bad   = 0;

   larpix_rx_packet_router_if #(.WIDTH(WIDTH)) uart_if ();

   larpix_rx_packet_router #(
      .WIDTH      (WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .uart              (uart_if),
      .data_pkt          (data_pkt),
      .data_valid        (data_valid),
      .data_ready        (data_ready),
      .fifo_count        (fifo_count),
      .cfg_rsp_valid     (cfg_rsp_valid),
      .cfg_rsp_chip_id   (cfg_rsp_chip_id),
      .cfg_rsp_addr      (cfg_rsp_addr),
      .cfg_rsp_data      (cfg_rsp_data),
      .cfg_rsp_ack       (cfg_rsp_ack),
      .pkt_count         (pkt_count),
      .parity_err_count  (parity_err_count),
      .bad_declare_count (bad_declare_count),
      .drop_count        (drop_count)
`ifdef LARPIX_RX_CHIP_FILTER_EN
      ,
      .filter_enable     (filter_enable),
      .filter_chip_id    (filter_chip_id),
      .filtered_count    (filtered_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [62:0] mk_pkt(input logic [1:0] decl, input logic [7:0] chip,
                                          input logic [7:0] addr, input logic [7:0] data,
                                          input logic [7:0] hi);
      logic [62:0] p;
      p        = '0;
      p[1:0]   = decl;
      p[9:2]   = chip;
      p[17:10] = addr;
      p[25:18] = data;
      p[62:55] = hi;
      return p;
   endfunction

   task automatic do_reset();
      reset            = 1'b1;
      data_ready       = 1'b0;
      cfg_rsp_ack      = 1'b0;
      uart_if.rx_empty = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Behaves as the UART: presents one packet, raises rx_empty once the
   // unload strobe is seen. Called at a negedge; returns after 8 negedges.
   // pop_at = k raises data_ready for the edge following negedge k.
   task automatic send_pkt(input logic [62:0] pkt, input logic par, input int pop_at,
                           output int uld_cycles, output int dv_first);
      uld_cycles           = 0;
      dv_first             = 0;
      uart_if.rx_data      = pkt;
      uart_if.parity_error = par;
      uart_if.rx_empty     = 1'b0;
      data_ready           = (pop_at == 0) ? 1'b0 : data_ready;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (uart_if.uld_rx_data) begin
            uld_cycles++;
            uart_if.rx_empty = 1'b1;
         end
         if (dv_first == 0 && data_valid) dv_first = k;
         data_ready = (k == pop_at);
      end
      uart_if.rx_empty = 1'b1;
      data_ready       = 1'b0;
   endtask

   typedef struct {
      logic [62:0] pkt;
      logic        par;
      logic        exp_valid;
      logic        exp_cfg;
      int          exp_perr;
      int          exp_bad;
      int          exp_fcnt;
   } vec_t;

   vec_t        vecs[7];
   logic [62:0] pkts[18];
   logic [62:0] exp_q[16];
   int          uc, dv;

   initial begin
      reset                = 1'b1;
      data_ready           = 1'b0;
      cfg_rsp_ack          = 1'b0;
      uart_if.rx_data      = '0;
      uart_if.rx_empty     = 1'b1;
      uart_if.parity_error = 1'b0;
`ifdef LARPIX_RX_CHIP_FILTER_EN
      filter_enable  = 1'b0;
      filter_chip_id = 8'h00;
`endif

      vecs[0] = '{mk_pkt(2'b01, 8'h01, 8'h02, 8'h03, 8'h80), 1'b0, 1'b1, 1'b0, 0, 0, 1};
      vecs[1] = '{mk_pkt(2'b10, 8'h07, 8'h11, 8'h22, 8'h00), 1'b0, 1'b0, 1'b0, 0, 0, 0};
      vecs[2] = '{mk_pkt(2'b11, 8'h07, 8'h11, 8'h22, 8'h00), 1'b0, 1'b0, 1'b1, 0, 0, 0};
      vecs[3] = '{mk_pkt(2'b01, 8'h01, 8'h02, 8'h03, 8'h00), 1'b1, 1'b0, 1'b0, 1, 0, 0};
      vecs[4] = '{mk_pkt(2'b11, 8'h07, 8'h11, 8'h22, 8'h00), 1'b1, 1'b0, 1'b0, 1, 0, 0};
      vecs[5] = '{mk_pkt(2'b00, 8'h05, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0, 1'b0, 0, 1, 0};
      vecs[6] = '{mk_pkt(2'b00, 8'h05, 8'h00, 8'h00, 8'h00), 1'b1, 1'b0, 1'b0, 1, 0, 0};

      // Reset state
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_uld",      uart_if.uld_rx_data, 0);
      check("rst_valid",    data_valid, 0);
      check("rst_fcnt",     fifo_count, 0);
      check("rst_cfg",      cfg_rsp_valid, 0);
      check("rst_cfg_chip", cfg_rsp_chip_id, 0);
      check("rst_pkt",      pkt_count, 0);
      check("rst_perr",     parity_err_count, 0);
      check("rst_bad",      bad_declare_count, 0);
      check("rst_drop",     drop_count, 0);

      // Table-driven single-packet vectors
      for (int i = 0; i < 7; i++) begin
         do_reset();
         send_pkt(vecs[i].pkt, vecs[i].par, 0, uc, dv);
         check($sformatf("vec%0d_valid", i), data_valid,       vecs[i].exp_valid);
         check($sformatf("vec%0d_cfg",   i), cfg_rsp_valid,    vecs[i].exp_cfg);
         check($sformatf("vec%0d_pkt",   i), pkt_count,        1);
         check($sformatf("vec%0d_perr",  i), parity_err_count, vecs[i].exp_perr);
         check($sformatf("vec%0d_bad",   i), bad_declare_count, vecs[i].exp_bad);
         check($sformatf("vec%0d_fcnt",  i), fifo_count,       vecs[i].exp_fcnt);
         check($sformatf("vec%0d_drop",  i), drop_count,       0);
      end

      // Single data packet: strobe width and latency
      do_reset();
      send_pkt(63'h0000_0000_0000_0405, 1'b0, 0, uc, dv);
      check("lat_uld_cycles", uc, 2);
      check("lat_dv_first",   dv, 4);
      check("lat_data",       data_pkt, 63'h0000_0000_0000_0405);
      check("lat_pkt_count",  pkt_count, 1);

      // Config read reply, ack, and overwrite without ack
      do_reset();
      send_pkt(mk_pkt(2'b11, 8'h10, 8'h05, 8'hA5, 8'h00), 1'b0, 0, uc, dv);
      check("cfg_valid", cfg_rsp_valid, 1);
      check("cfg_chip",  cfg_rsp_chip_id, 8'h10);
      check("cfg_addr",  cfg_rsp_addr, 8'h05);
      check("cfg_data",  cfg_rsp_data, 8'hA5);
      cfg_rsp_ack = 1'b1;
      @(negedge clk);
      cfg_rsp_ack = 1'b0;
      check("cfg_ack_clear", cfg_rsp_valid, 0);
      send_pkt(mk_pkt(2'b11, 8'h10, 8'h05, 8'hA5, 8'h00), 1'b0, 0, uc, dv);
      send_pkt(mk_pkt(2'b11, 8'h22, 8'h33, 8'h44, 8'h00), 1'b0, 0, uc, dv);
      check("cfg_ow_valid", cfg_rsp_valid, 1);
      check("cfg_ow_chip",  cfg_rsp_chip_id, 8'h22);
      check("cfg_ow_addr",  cfg_rsp_addr, 8'h33);
      check("cfg_ow_data",  cfg_rsp_data, 8'h44);
      check("cfg_ow_drop",  drop_count, 1);

      // FIFO overflow, push+pop while full, FIFO-order drain
      do_reset();
      for (int i = 0; i < 18; i++)
         pkts[i] = mk_pkt(2'b01, 8'(i), 8'(i * 3), 8'(8'hF0 ^ 8'(i)), 8'(i) | 8'h80);
      for (int i = 0; i < 17; i++)
         send_pkt(pkts[i], 1'b0, 0, uc, dv);
      check("ovf_fcnt",    fifo_count, 16);
      check("ovf_drop",    drop_count, 1);
      check("ovf_pkt_sat", pkt_count, 15);
      send_pkt(pkts[17], 1'b0, 3, uc, dv);
      check("fullpp_fcnt", fifo_count, 16);
      check("fullpp_drop", drop_count, 1);
      for (int i = 0; i < 15; i++) exp_q[i] = pkts[i + 1];
      exp_q[15] = pkts[17];
      for (int i = 0; i < 16; i++) begin
         check($sformatf("drain%0d_valid", i), data_valid, 1);
         check($sformatf("drain%0d_data", i),  data_pkt, exp_q[i]);
         data_ready = 1'b1;
         @(negedge clk);
      end
      @(negedge clk);
      data_ready = 1'b0;
      check("drain_empty_fcnt",  fifo_count, 0);
      check("drain_empty_valid", data_valid, 0);

      // Reset during CAPTURE
      do_reset();
      send_pkt(63'h0000_0000_0000_0405, 1'b0, 0, uc, dv);
      uart_if.rx_data      = mk_pkt(2'b01, 8'h03, 8'h00, 8'h00, 8'h00);
      uart_if.parity_error = 1'b0;
      uart_if.rx_empty     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rcap_uld_pre", uart_if.uld_rx_data, 1);
      reset = 1'b1;
      #1;
      check("rcap_uld",   uart_if.uld_rx_data, 0);
      check("rcap_pkt",   pkt_count, 0);
      check("rcap_fcnt",  fifo_count, 0);
      check("rcap_valid", data_valid, 0);
      @(negedge clk);
      reset            = 1'b0;
      uart_if.rx_empty = 1'b1;
      @(negedge clk);
      send_pkt(63'h0000_0000_0000_0009, 1'b0, 0, uc, dv);
      check("rcap_next_pkt",  pkt_count, 1);
      check("rcap_next_fcnt", fifo_count, 1);
      check("rcap_next_data", data_pkt, 63'h0000_0000_0000_0009);

`ifdef LARPIX_RX_CHIP_FILTER_EN
      // Chip filter
      do_reset();
      filter_enable  = 1'b1;
      filter_chip_id = 8'h1F;
      send_pkt(mk_pkt(2'b01, 8'h1F, 8'h01, 8'h02, 8'h00), 1'b0, 0, uc, dv);
      send_pkt(mk_pkt(2'b01, 8'h00, 8'h01, 8'h02, 8'h00), 1'b0, 0, uc, dv);
      send_pkt(mk_pkt(2'b11, 8'h00, 8'h09, 8'h0A, 8'h00), 1'b0, 0, uc, dv);
      check("filt_fcnt",  fifo_count, 1);
      check("filt_count", filtered_count, 1);
      check("filt_data",  data_pkt, mk_pkt(2'b01, 8'h1F, 8'h01, 8'h02, 8'h00));
      check("filt_cfg",   cfg_rsp_valid, 1);
      filter_enable = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
